decompr: RTL and testbench

Stereo sample expander that inverts the fixed piecewise-linear audio compression curve used on the sound mixer output path. It runs with gain 1/2 below the knee and slope 4 above it. The block takes compressed signed 16-bit L/R pairs over a valid/ready handshake and pushes both channels through one shared two-step datapath. It returns the expanded pair over a second valid/ready handshake. It sits between compressed-sample sources (capture/loopback of mixer output) and consumers that need linear PCM.

---
 rtl/decompr_if.sv | 21 ++
 rtl/decompr.sv | 116 +++++++++++
 tb/tb_decompr.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/decompr_if.sv
// rtl/decompr_if.sv - compressed-in / expanded-out stereo sample handshake bundle
interface decompr_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_l;
    logic [15:0] in_r;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_l;
    logic [15:0] out_r;

    modport master (
        output in_valid, in_l, in_r, out_ready,
        input  in_ready, out_valid, out_l, out_r
    );

    modport slave (
        input  in_valid, in_l, in_r, out_ready,
        output in_ready, out_valid, out_l, out_r
    );
endinterface

// File: rtl/decompr.sv
// rtl/decompr.sv - stereo piecewise-linear expander (gain 1/2 below knee, slope 4 above)
// Optional DECOMPR_ROUND_EN: reconstruct upper-region bucket centre (+2) instead of floor.
module decompr (
    input  logic clk,
    input  logic reset,
    decompr_if.slave bus
);
    localparam logic [15:0] KNEE_IN  = 16'd28088;
    localparam logic [15:0] KNEE_OUT = 16'd14044;
`ifdef DECOMPR_ROUND_EN
    localparam logic [15:0] ROUND    = 16'd2;
`else
    localparam logic [15:0] ROUND    = 16'd0;
`endif

    typedef enum logic [2:0] {IDLE, MAG_L, EXP_L, MAG_R, EXP_R, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] hold_l_q, hold_l_d;
    logic [15:0] hold_r_q, hold_r_d;
    logic        sign_q, sign_d;
    logic [15:0] mag_q, mag_d;
    logic [15:0] out_l_q, out_l_d;
    logic [15:0] out_r_q, out_r_d;
    logic        out_valid_q, out_valid_d;

    logic        in_ready;
    logic        accept;
    logic [15:0] mag_src;
    logic [15:0] exp_mag;
    logic [15:0] exp_res;

    always_comb begin
        state_d   = state_q;
        hold_l_d  = hold_l_q;
        hold_r_d  = hold_r_q;
        sign_d    = sign_q;
        mag_d     = mag_q;
        out_l_d   = out_l_q;
        out_r_d   = out_r_q;

        in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
        accept   = bus.in_valid && in_ready;

        // Shared datapath: MAG stage picks the channel, EXP stage reuses sign/mag regs.
        mag_src = (state_q == MAG_L) ? hold_l_q : hold_r_q;
        if (mag_q < KNEE_IN) begin
            exp_mag = mag_q >> 1;
        end else begin
            exp_mag = ((mag_q - KNEE_IN) << 2) + KNEE_OUT + ROUND;
        end
        exp_res = sign_q ? (~exp_mag + 16'd1) : exp_mag;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    hold_l_d = bus.in_l;
                    hold_r_d = bus.in_r;
                    state_d  = MAG_L;
                end
            end
            MAG_L, MAG_R: begin
                sign_d  = mag_src[15];
                mag_d   = mag_src[15] ? (~mag_src + 16'd1) : mag_src;
                state_d = (state_q == MAG_L) ? EXP_L : EXP_R;
            end
            EXP_L: begin
                out_l_d = exp_res;
                state_d = MAG_R;
            end
            EXP_R: begin
                out_r_d = exp_res;
                state_d = DONE;
            end
            DONE: begin
                if (accept) begin
                    hold_l_d = bus.in_l;
                    hold_r_d = bus.in_r;
                    state_d  = MAG_L;
                end else if (bus.out_ready) begin
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            sign_q      <= 1'b0;
            mag_q       <= '0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            out_l_q     <= out_l_d;
            out_r_q     <= out_r_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_l     = out_l_q;
    assign bus.out_r     = out_r_q;
endmodule

// File: tb/tb_decompr.sv
// tb/tb_decompr.sv - randomized self-checking bench for decompr against an arithmetic reference
module tb_decompr;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    decompr_if bus ();
    decompr dut (.clk(clk), .reset(reset), .bus(bus));

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Reference: inverse of the compressor curve on signed integers.
    function automatic logic [15:0] expand(input logic [15:0] x);
        int v, m, e;
        v = int'($signed(x));
        m = (v < 0) ? -v : v;
        if (m < 28088) begin
            e = m / 2;
        end else begin
            e = (m - 28088) * 4 + 14044;
`ifdef DECOMPR_ROUND_EN
            e = e + 2;
`endif
        end
        return 16'((v < 0) ? -e : e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_pair(input logic [15:0] l, input logic [15:0] r, input string tag);
        int cnt;
        bus.in_l = l;
        bus.in_r = r;
        bus.in_valid = 1'b1;
        cnt = 0;
        while (!bus.in_ready && cnt < 20) begin
            tick();
            cnt++;
        end
        check({tag, "/in_ready"}, 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        cnt = 0;
        while (!bus.out_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        check({tag, "/latency"}, 32'(cnt), 32'd4);
        check({tag, "/out_l"}, 32'(bus.out_l), 32'(expand(l)));
        check({tag, "/out_r"}, 32'(bus.out_r), 32'(expand(r)));
        tick();
        check({tag, "/valid_drop"}, 32'(bus.out_valid), 32'd0);
    endtask

    logic [15:0] sl [8];
    logic [15:0] sr [8];
    logic [15:0] bl, br, al, ar;
    int cnt, idx, outs, last_c, highs;
    logic acc;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_l      = '0;
        bus.in_r      = '0;
        bus.out_ready = 1'b1;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        check("rst/in_ready", 32'(bus.in_ready), 32'd1);
        check("rst/out_valid", 32'(bus.out_valid), 32'd0);
        check("rst/out_l", 32'(bus.out_l), 32'd0);
        check("rst/out_r", 32'(bus.out_r), 32'd0);

        run_pair(16'd100, 16'hff9c, "basic");
        run_pair(16'd28088, 16'd30000, "knee");
        run_pair(16'h8000, 16'h7fff, "extreme");
        run_pair(16'd1, 16'hffff, "tiny");
        run_pair(16'h9248, 16'd0, "negknee");
        run_pair(16'd28087, 16'd28089, "edge");

        for (int i = 0; i < 16; i++) begin
            run_pair(16'($urandom), 16'($urandom), "rand");
        end

        // Backpressure: hold in DONE, offer next pair meanwhile.
        al = 16'($urandom);
        ar = 16'($urandom);
        bl = 16'($urandom);
        br = 16'($urandom);
        bus.out_ready = 1'b0;
        bus.in_l = al;
        bus.in_r = ar;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        cnt = 0;
        while (!bus.out_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        check("bp/latency", 32'(cnt), 32'd4);
        bus.in_l = bl;
        bus.in_r = br;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("bp/in_ready_low", 32'(bus.in_ready), 32'd0);
            check("bp/valid_held", 32'(bus.out_valid), 32'd1);
            check("bp/out_l_held", 32'(bus.out_l), 32'(expand(al)));
            check("bp/out_r_held", 32'(bus.out_r), 32'(expand(ar)));
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp/in_ready_release", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("bp/valid_after", 32'(bus.out_valid), 32'd0);
        cnt = 0;
        while (!bus.out_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        check("bp/latency2", 32'(cnt), 32'd4);
        check("bp/out_l", 32'(bus.out_l), 32'(expand(bl)));
        check("bp/out_r", 32'(bus.out_r), 32'(expand(br)));
        tick();

        // Back-to-back stream with both sides always ready.
        for (int i = 0; i < 8; i++) begin
            sl[i] = 16'($urandom);
            sr[i] = 16'($urandom);
        end
        sl[3] = 16'h8000;
        sr[5] = 16'h7fff;
        idx = 0;
        outs = 0;
        last_c = 0;
        bus.in_l = sl[0];
        bus.in_r = sr[0];
        bus.in_valid = 1'b1;
        for (int c = 0; c < 200 && outs < 8; c++) begin
            acc = bus.in_valid & bus.in_ready;
            if (bus.out_valid && bus.out_ready) begin
                check("stream/out_l", 32'(bus.out_l), 32'(expand(sl[outs])));
                check("stream/out_r", 32'(bus.out_r), 32'(expand(sr[outs])));
                if (outs > 0) check("stream/spacing", 32'(c - last_c), 32'd5);
                last_c = c;
                outs++;
            end
            tick();
            if (acc) begin
                idx++;
                if (idx < 8) begin
                    bus.in_l = sl[idx];
                    bus.in_r = sr[idx];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        bus.in_valid = 1'b0;
        check("stream/count", 32'(outs), 32'd8);
        tick();

        // Reset while the left channel is in its expand step.
        bus.in_l = 16'd1000;
        bus.in_r = 16'hf830;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst/out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst/out_l", 32'(bus.out_l), 32'd0);
        check("midrst/out_r", 32'(bus.out_r), 32'd0);
        check("midrst/in_ready", 32'(bus.in_ready), 32'd1);
        highs = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.out_valid) highs++;
            tick();
        end
        check("midrst/no_stale", 32'(highs), 32'd0);

        run_pair(16'd500, 16'hfe0c, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
